// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the scoreboarded register file
package regfile_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } rf_state_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;

    // Write port count is architectural: port 1 always wins over port 0.
    localparam int NUM_WR = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for hazard detection
// Ports: clk, rst_n (async low); en (updates and lookups enabled once ready);
//        iss_en/iss_addr set busy; we/wa/wb_clr clear busy; ra -> rbusy lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic [NUM_WR-1:0]    we,
    input  logic [NUM_WR*AW-1:0] wa,
    input  logic [NUM_WR-1:0]    wb_clr,
    input  logic [NUM_RD*AW-1:0] ra,
    output logic [NUM_RD-1:0]    rbusy
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Clears are applied first so a same-edge issue to the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (en) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (we[j] && wb_clr[j]) begin
                    busy_nxt[wa[j*AW +: AW]] = 1'b0;
                end
            end
            if (iss_en) begin
                busy_nxt[iss_addr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Lookups show the pre-edge state; no forwarding of same-cycle set/clear.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
        assign rbusy[k] = en & busy[ra[k*AW +: AW]];
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised multi-port register file with scoreboard
// Ports: clk, rst_n (async low), ready; ra/rd/rbusy read ports (packed per port);
//        we0/wa0/wd0, we1/wa1/wd1 write ports (port 1 wins); iss_en/iss_addr issue;
//        wb_clr per-write-port busy clear.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    ready,
    input  logic [NUM_RD*AW-1:0]    ra,
    output logic [NUM_RD*WIDTH-1:0] rd,
    output logic [NUM_RD-1:0]       rbusy,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [AW-1:0]           wa0,
    input  logic [AW-1:0]           wa1,
    input  logic [WIDTH-1:0]        wd0,
    input  logic [WIDTH-1:0]        wd1,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    input  logic [NUM_WR-1:0]       wb_clr
);

    localparam logic [AW:0] INIT_LAST = (AW+1)'(DEPTH - 1);

    rf_state_t        state, state_nxt;
    logic [AW:0]      init_cnt, init_cnt_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             active;
    logic             out_en;
    logic             w0_ok, w1_ok;

    assign active = (state == ST_READY);
    // rst_n is folded in so outputs are quiet even before the first reset edge.
    assign out_en = active & rst_n;
    assign ready  = out_en;

    // The counter is one bit wider than the index; it stops counting once the
    // state leaves INIT rather than wrapping.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        if (state == ST_INIT) begin
            init_cnt_nxt = init_cnt + (AW+1)'(1);
            if (init_cnt == INIT_LAST) begin
                state_nxt = ST_READY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Qualified writes: only once ready, and never to the hardwired zero register.
    assign w0_ok = active && we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign w1_ok = active && we1 && !((ZERO_REG != 0) && (wa1 == '0));

    // Storage has no reset; the INIT sweep zeroes it one entry per cycle.
    // Port 1 is assigned last so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (!active) begin
            mem[init_cnt[AW-1:0]] <= '0;
        end else begin
            if (w0_ok) mem[wa0] <= wd0;
            if (w1_ok) mem[wa1] <= wd1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] v;

        assign a = ra[k*AW +: AW];

        always_comb begin
            v = mem[a];
            if (BYPASS != 0) begin
                if (w1_ok && (wa1 == a)) begin
                    v = wd1;
                end else if (w0_ok && (wa0 == a)) begin
                    v = wd0;
                end
            end
            if ((ZERO_REG != 0) && (a == '0)) begin
                v = '0;
            end
            if (!out_en) begin
                v = '0;
            end
        end

        assign rd[k*WIDTH +: WIDTH] = v;
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (out_en),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .we       ({we1, we0}),
        .wa       ({wa1, wa0}),
        .wb_clr   (wb_clr),
        .ra       (ra),
        .rbusy    (rbusy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized self-checking bench for regfile_sb
module tb_regfile_sb;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [AW-1:0]  ra0, ra1, wa0, wa1, iss_addr;
    logic           we0, we1, iss_en;
    logic [W-1:0]   wd0, wd1;
    logic [1:0]     wb_clr;
    logic [2*AW-1:0] ra;
    logic           ready, nb_ready;
    logic [2*W-1:0] rd, nb_rd;
    logic [1:0]     rbusy, nb_rbusy;

    logic [W-1:0]   m_mem [D];
    bit             m_busy [D];
    int             m_cnt;
    int             n_vec;
    int             n_err;

    assign ra = {ra1, ra0};

    always #5 clk = ~clk;

    regfile_sb #(.BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ready(ready), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .wb_clr(wb_clr)
    );

    regfile_sb #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .ready(nb_ready), .ra(ra), .rd(nb_rd), .rbusy(nb_rbusy),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .wb_clr(wb_clr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: registers as an array, busy as a flag per register,
    // readiness as "DEPTH clock edges seen since reset was released".
    function automatic bit m_ready();
        return (rst_n === 1'b1) && (m_cnt >= D);
    endfunction

    function automatic logic [W-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
        if (!m_ready() || a == 0) return '0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic logic m_rbusy(input logic [AW-1:0] a);
        return m_ready() ? m_busy[a] : 1'b0;
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        for (int i = 0; i < D; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rst_n !== 1'b1) begin
            model_clear();
        end else if (m_cnt < D) begin
            m_cnt++;
        end else begin
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (we0 && wb_clr[0]) m_busy[wa0] = 1'b0;
            if (we1 && wb_clr[1]) m_busy[wa1] = 1'b0;
            if (iss_en) m_busy[iss_addr] = 1'b1;
            m_busy[0] = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("ready",    64'(ready),      64'(m_ready()));
        chk("nb_ready", 64'(nb_ready),   64'(m_ready()));
        chk("rd0",      64'(rd[W-1:0]),  64'(m_rd(ra0, 1'b1)));
        chk("rd1",      64'(rd[2*W-1:W]), 64'(m_rd(ra1, 1'b1)));
        chk("nb_rd0",   64'(nb_rd[W-1:0]),  64'(m_rd(ra0, 1'b0)));
        chk("nb_rd1",   64'(nb_rd[2*W-1:W]), 64'(m_rd(ra1, 1'b0)));
        chk("rbusy0",   64'(rbusy[0]),   64'(m_rbusy(ra0)));
        chk("rbusy1",   64'(rbusy[1]),   64'(m_rbusy(ra1)));
        chk("nb_rbusy", 64'(nb_rbusy),   64'({m_rbusy(ra1), m_rbusy(ra0)}));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked on
    // the falling edge; the model advances on the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, D - 1));
    endfunction

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0; wb_clr = 2'b00;
        wd0 = '0;   wd1 = '0;   wa0 = '0;     wa1 = '0;  iss_addr = '0;
    endtask

    task automatic rand_inputs();
        we0 = 1'($urandom_range(0, 1));
        we1 = 1'($urandom_range(0, 1));
        iss_en = 1'($urandom_range(0, 1));
        wb_clr = 2'($urandom_range(0, 3));
        wa0 = raddr(); wa1 = raddr(); iss_addr = raddr();
        ra0 = raddr(); ra1 = raddr();
        wd0 = $urandom; wd1 = $urandom;
    endtask

    task automatic init_and_sweep();
        for (int i = 0; i < D; i++) begin
            rand_inputs();
            cycle();
            if (i == D - 2) chk("init_not_ready", 64'(ready), 64'd0);
        end
        idle();
        #1 chk("init_ready", 64'(ready), 64'd1);
        for (int a = 0; a < D; a++) begin
            ra0 = AW'(a);
            ra1 = AW'(D - 1 - a);
            #1 chk("init_zero", rd, 64'd0);
            cycle();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        ra0 = '0; ra1 = '0;
        model_clear();

        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_rd",    rd, 64'd0);
        chk("rst_rbusy", 64'(rbusy), 64'd0);
        repeat (3) begin
            rand_inputs();
            cycle();
        end

        rst_n = 1'b1;
        init_and_sweep();

        // Basic write/read.
        idle(); we0 = 1'b1; wa0 = 5'd15; wd0 = 32'd1234;
        cycle();
        idle(); ra0 = 5'd15;
        #1 chk("wr15", 64'(rd[W-1:0]), 64'd1234);
        cycle();
        we0 = 1'b1; wa0 = 5'd30; wd0 = 32'd56781;
        cycle();
        idle(); ra0 = 5'd30; ra1 = 5'd15;
        #1 chk("wr30_p0", 64'(rd[W-1:0]), 64'd56781);
        chk("wr15_p1", 64'(rd[2*W-1:W]), 64'd1234);
        cycle();

        // Collision on address 7: port 1 wins, bypass shows it immediately.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'd5;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'd9;
        ra0 = 5'd7;
        #1 chk("byp_collide", 64'(rd[W-1:0]), 64'd9);
        chk("nobyp_old", 64'(nb_rd[W-1:0]), 64'd0);
        cycle();
        idle();
        #1 chk("mem7", 64'(rd[W-1:0]), 64'd9);
        chk("nb_mem7", 64'(nb_rd[W-1:0]), 64'd9);
        cycle();

        // Zero register ignores write, bypass and issue.
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd0; ra0 = 5'd0;
        #1 chk("zero_byp", 64'(rd[W-1:0]), 64'd0);
        cycle();
        idle();
        #1 chk("zero_rd", 64'(rd[W-1:0]), 64'd0);
        chk("zero_busy", 64'(rbusy[0]), 64'd0);
        cycle();

        // Scoreboard set, set-wins-over-clear, clear.
        iss_en = 1'b1; iss_addr = 5'd3; ra0 = 5'd3;
        #1 chk("sb_pre", 64'(rbusy[0]), 64'd0);
        cycle();
        idle();
        #1 chk("sb_set", 64'(rbusy[0]), 64'd1);
        iss_en = 1'b1; iss_addr = 5'd3;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'd77; wb_clr = 2'b01;
        cycle();
        idle();
        #1 chk("sb_set_wins", 64'(rbusy[0]), 64'd1);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'd78; wb_clr = 2'b01;
        cycle();
        idle();
        #1 chk("sb_clr", 64'(rbusy[0]), 64'd0);
        cycle();

        repeat (150) begin
            rand_inputs();
            cycle();
        end

        // Reset pulse between edges.
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_rd",    rd, 64'd0);
        check_all();
        #1 rst_n = 1'b1;
        init_and_sweep();

        repeat (150) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
